// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller for the CP0 interrupt input.
// Synchronises N_SRC raw lines and latches them per source, either as a level or on a
// rising edge. It masks them, picks the lowest enabled index, and holds one request
// until CP0 raises exl. The taken source stays in service until software writes STATUS (EOI).
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   src             raw interrupt lines (asynchronous)
//   exl             CP0 exception-level flag; its rising edge means the request was taken
//   cs, we, addr,   register bank access from the data-memory decode
//   wd, rd          write data / combinational read data (0 when cs=0)
//   irq, irq_id     request to CP0 and index of requesting / in-service source
// Register map: 0 PENDING (W1C, edge bits), 1 MASK, 2 EDGE_SEL, 3 STATUS (write = EOI).
module irq_ctrl #(
  parameter int unsigned ID_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [(1 << ID_W)-1:0]     src,
  input  logic                       exl,
  input  logic                       cs,
  input  logic                       we,
  input  logic [1:0]                 addr,
  input  logic [31:0]                wd,
  output logic [31:0]                rd,
  output logic                       irq,
  output logic [ID_W-1:0]            irq_id
);

  localparam int unsigned N_SRC = 1 << ID_W;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAssert  = 2'd1,
    StService = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   irq_id_q, irq_id_d;
  logic [N_SRC-1:0]  s1_q, s2_q, s3_q;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  mask_q, edge_sel_q;
  logic              exl_q;

  logic [N_SRC-1:0]  rise, eligible, take_vec;
  logic [ID_W-1:0]   pick;
  logic              take;
  logic              wr_pend, wr_mask, wr_edge, eoi;

  // Upper write-data bits have no backing storage.
  logic unused_wd;
  assign unused_wd = ^wd[31:N_SRC];

  assign wr_pend = cs & we & (addr == 2'd0);
  assign wr_mask = cs & we & (addr == 2'd1);
  assign wr_edge = cs & we & (addr == 2'd2);
  assign eoi     = cs & we & (addr == 2'd3);

  assign rise     = s2_q & ~s3_q;
  assign eligible = pending_q & mask_q;

  // Lowest index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    pick = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) pick = ID_W'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      take_vec[i] = take && (irq_id_q == ID_W'(i));
    end
  end

  // Level bits mirror the synchronised line; edge bits latch, and a new rise beats any clear.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      if (!edge_sel_q[i])                      pending_d[i] = s2_q[i];
      else if (rise[i])                        pending_d[i] = 1'b1;
      else if ((wr_pend && wd[i]) || take_vec[i]) pending_d[i] = 1'b0;
      else                                     pending_d[i] = pending_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    take     = 1'b0;
    case (state_q)
      StIdle: begin
        if (|eligible) begin
          state_d  = StAssert;
          irq_id_d = pick;
        end
      end
      StAssert: begin
        // Being taken outranks a simultaneous withdrawal.
        if (exl && !exl_q) begin
          state_d = StService;
          take    = 1'b1;
        end else if (!eligible[irq_id_q]) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      irq_id_q   <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      edge_sel_q <= '0;
      exl_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      s1_q      <= src;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
      exl_q     <= exl;
      if (wr_mask) mask_q     <= wd[N_SRC-1:0];
      if (wr_edge) edge_sel_q <= wd[N_SRC-1:0];
    end
  end

  assign irq    = (state_q == StAssert);
  assign irq_id = irq_id_q;

  always_comb begin
    rd = '0;
    if (cs) begin
      case (addr)
        2'd0: rd[N_SRC-1:0]  = pending_q;
        2'd1: rd[N_SRC-1:0]  = mask_q;
        2'd2: rd[N_SRC-1:0]  = edge_sel_q;
        2'd3: rd[ID_W+2:0]   = {state_q, irq, irq_id_q};
        default: rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  src;
  logic        exl;
  logic        cs;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;
  logic [2:0]  irq_id;

  int total;
  int bad;

  irq_ctrl #(.ID_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .src    (src),
    .exl    (exl),
    .cs     (cs),
    .we     (we),
    .addr   (addr),
    .wd     (wd),
    .rd     (rd),
    .irq    (irq),
    .irq_id (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; all timing is counted in falling edges.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Write lands on the rising edge inside the next cycle.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wd = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; wd = '0;
  endtask

  task automatic rchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    cs = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(tag, rd, exp);
    cs = 1'b0;
  endtask

  task automatic ichk(input string tag, input logic exp_irq, input logic [2:0] exp_id);
    chk({tag, "_irq"}, {31'b0, irq}, {31'b0, exp_irq});
    chk({tag, "_id"}, {29'b0, irq_id}, {29'b0, exp_id});
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; src = 8'hFF; exl = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; wd = '0;

    // Reset with all lines high
    tick(2);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    rchk("rst_status", 2'd3, 32'h0);
    rchk("rst_mask", 2'd1, 32'h0);
    rchk("rst_rd_nocs", 2'd0, 32'h0);
    src = 8'h00; rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_mask0_irq", {31'b0, irq}, 32'd0);
    end

    // Edge latch and priority
    wr(2'd2, 32'hFF);
    wr(2'd1, 32'hFFFF_FF0C);
    rchk("mask_upper_ignored", 2'd1, 32'h0C);
    src = 8'h0C; tick(1); src = 8'h00;
    tick(1); chk("edge_k1_irq", {31'b0, irq}, 32'd0);
    tick(1); rchk("edge_pend", 2'd0, 32'h0C);
    chk("edge_k2_irq", {31'b0, irq}, 32'd0);
    tick(1); ichk("edge_k3", 1'b1, 3'd2);
    rchk("edge_status_assert", 2'd3, 32'h1A);
    exl = 1'b1; tick(1);
    rchk("svc_status", 2'd3, 32'h22);
    rchk("svc_pend", 2'd0, 32'h08);
    exl = 1'b0; tick(2);
    rchk("svc_hold_after_exl_fall", 2'd3, 32'h22);
    wr(2'd3, 32'h0);
    rchk("eoi_idle_status", 2'd3, 32'h02);
    tick(1); ichk("eoi_next", 1'b1, 3'd3);
    exl = 1'b1; tick(1); exl = 1'b0;
    wr(2'd3, 32'h0);
    tick(1);
    rchk("edge_clean_pend", 2'd0, 32'h0);
    chk("edge_clean_irq", {31'b0, irq}, 32'd0);

    // Level mode, withdrawn before exl
    wr(2'd2, 32'h0);
    wr(2'd1, 32'h01);
    src = 8'h01; tick(3);
    chk("lvl_k2_irq", {31'b0, irq}, 32'd0);
    tick(1); ichk("lvl_k3", 1'b1, 3'd0);
    src = 8'h00; tick(2);
    rchk("lvl_drop_pend_hold", 2'd0, 32'h01);
    tick(1);
    rchk("lvl_drop_pend", 2'd0, 32'h00);
    chk("lvl_drop_irq_hold", {31'b0, irq}, 32'd1);
    tick(1);
    rchk("lvl_drop_status", 2'd3, 32'h00);

    // Masking withdrawal
    wr(2'd2, 32'h20);
    wr(2'd1, 32'h20);
    src = 8'h20; tick(1); src = 8'h00;
    tick(3); ichk("msk_req", 1'b1, 3'd5);
    wr(2'd1, 32'h0);
    tick(1);
    chk("msk_withdraw_irq", {31'b0, irq}, 32'd0);
    rchk("msk_pend_kept", 2'd0, 32'h20);
    wr(2'd1, 32'h20);
    tick(1); ichk("msk_reenable", 1'b1, 3'd5);
    wr(2'd1, 32'h0);
    wr(2'd0, 32'h20);
    rchk("msk_w1c", 2'd0, 32'h00);

    // W1C in the same cycle as a rise: set wins
    wr(2'd2, 32'h10);
    src = 8'h10; tick(2);
    wr(2'd0, 32'h10);
    rchk("setclr_pend", 2'd0, 32'h10);
    src = 8'h00;
    wr(2'd0, 32'h10);
    rchk("w1c_pend", 2'd0, 32'h00);

    // Reset while in service
    wr(2'd2, 32'hFF);
    wr(2'd1, 32'h40);
    src = 8'h40; tick(1); src = 8'h00;
    tick(3); ichk("mid_req", 1'b1, 3'd6);
    exl = 1'b1; tick(1); exl = 1'b0;
    rchk("mid_svc_status", 2'd3, 32'h26);
    rst = 1'b1;
    #1;
    ichk("mid_rst", 1'b0, 3'd0);
    rchk("mid_rst_pend", 2'd0, 32'h0);
    rchk("mid_rst_status", 2'd3, 32'h0);
    rchk("mid_rst_edge", 2'd2, 32'h0);
    tick(1); rst = 1'b0;
    wr(2'd2, 32'h02);
    wr(2'd1, 32'h02);
    src = 8'h02; tick(1); src = 8'h00;
    tick(2); chk("post_rst_k2_irq", {31'b0, irq}, 32'd0);
    tick(1); ichk("post_rst", 1'b1, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
